ec_decim: RTL
=============

EC_DECIM -- requirements
Module: ec_decim

Interface
REQ-001 The block SHALL have parameter N, default 16, sample and output width in bits.
REQ-002 The block SHALL have parameter LOG2_D, default 2, giving decimation factor D = 2^LOG2_D (range 0..8).
REQ-003 The block SHALL have parameter DEPTH, default 4, giving output FIFO depth (power of two, >= 2).
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_rst  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port i_y  input  N  unsigned sample from the upstream difference-equation stage.
REQ-007 The block SHALL have port i_en  input  1  qualifies i_y; a sample is accepted only on cycles with i_en=1.
REQ-008 The block SHALL have port o_data  output  N  decimated average at the FIFO head.
REQ-009 The block SHALL have port o_valid  output  1  FIFO non-empty.
REQ-010 The block SHALL have port i_ready  input  1  consumer ready.
REQ-011 The block SHALL have port o_level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-012 The block SHALL have port o_overflow  output  1  sticky flag, set when a result is dropped.

Function
REQ-013 Accumulator SHALL be N+LOG2_D bits wide, unsigned; a sum of D full-scale samples SHALL never wrap.
REQ-014 Phase counter SHALL count accepted samples 0..D-1 and wrap to 0 after the D-th; cycles with i_en=0 SHALL NOT change the counter or the accumulator.
REQ-015 On the D-th accepted sample, the result SHALL be (accumulator + i_y) >> LOG2_D, truncated to N bits. That cycle SHALL push the result and clear the accumulator.
REQ-016 A pushed result SHALL appear at o_data with o_valid=1 on the cycle after the D-th sample when the FIFO was empty (latency 1 cycle).
REQ-017 FIFO SHALL be show-ahead: o_data always presents the oldest entry, with results in push order.
REQ-018 Transfer SHALL occur iff o_valid=1 and i_ready=1. o_data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-019 With LOG2_D=0, every accepted sample SHALL be pushed unchanged.
REQ-020 Push when full with no pop SHALL drop the new result, leave the FIFO unchanged and set o_overflow=1.
REQ-021 Simultaneous push and pop when full SHALL succeed with no drop; o_level SHALL remain DEPTH.
REQ-022 Simultaneous push and pop when empty SHALL NOT occur, because o_valid=0; the push SHALL complete normally.
REQ-023 o_level SHALL equal the entry count after each edge, in the range 0..DEPTH.
REQ-024 o_overflow SHALL clear only on reset.

Reset
REQ-025 On a rising clk with i_rst=0, the block SHALL set accumulator, phase counter, FIFO pointers, o_level, o_overflow and o_valid to 0. o_data SHALL read 0.
REQ-026 Reset SHALL discard any partial block mid-accumulation and all FIFO contents; the first accepted sample after release SHALL be phase 0.
REQ-027 i_rst SHALL take priority over i_en and i_ready on the same edge.

Configuration
REQ-028 With macro EC_DECIM_ROUND_EN defined, the result SHALL be (sum + 2^(LOG2_D-1)) >> LOG2_D, computed in N+LOG2_D bits and saturated to 2^N-1 (round half up); with LOG2_D=0 there SHALL be no change.
REQ-029 Without EC_DECIM_ROUND_EN, the result SHALL be plain truncation per REQ-015.

Verification
REQ-030 Reset: hold i_rst=0 for 2 cycles with i_en=1 -> o_valid=0, o_level=0, o_overflow=0, o_data=0.
REQ-031 Basic: N=16, LOG2_D=2, i_ready=1, i_y=10,20,30,40 consecutive -> o_data=25, o_valid=1 one cycle after the 4th sample. With samples 1,2,2,2: o_data=1 without the macro, 2 with EC_DECIM_ROUND_EN.
REQ-032 Full-scale and gaps: four samples of 0xFFFF separated by i_en=0 idle cycles -> o_data=0xFFFF (also with rounding); idle cycles ignored.
REQ-033 Backpressure: i_ready=0, feed 5 blocks averaging 1..5 -> o_level=4, o_overflow=1. Then i_ready=1 -> outputs 1,2,3,4 in order, o_level returns to 0, o_overflow stays 1.
REQ-034 Full with concurrent pop: FIFO at 4 and i_ready=1 on the cycle a 5th result is pushed -> no drop, o_level=4, o_overflow unchanged.
REQ-035 Mid-block reset: 2 samples of 100, i_rst=0 for one cycle, then 4 samples of 8 -> single result o_data=8.

Source files
------------

// File: rtl/ec_decim.sv
// ec_decim: block-average decimator feeding a show-ahead output FIFO.
// Accepts D = 2^LOG2_D qualified samples, pushes their average, drops
// results (sticky o_overflow) when the FIFO is full and not being drained.
// Optional feature: define EC_DECIM_ROUND_EN for round-half-up averaging
// (saturated to 2^N-1) instead of plain truncation.
module ec_decim #(
    parameter int N      = 16,
    parameter int LOG2_D = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic [N-1:0]             i_y,
    input  logic                     i_en,
    output logic [N-1:0]             o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int ACCW = N + LOG2_D;
    localparam int PW   = (LOG2_D > 0) ? LOG2_D : 1;

    logic [ACCW-1:0] acc_q, acc_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    mem_q [DEPTH];

    logic [ACCW-1:0] sum;
    logic [N-1:0]    result;
    logic            phase_last;
    logic            push, pop, full, do_push;

    // D-1 is all ones in LOG2_D bits; with D=1 every sample closes a block.
    assign phase_last = (LOG2_D == 0) ? 1'b1 : (phase_q == {PW{1'b1}});
    assign sum        = acc_q + ACCW'(i_y);

`ifdef EC_DECIM_ROUND_EN
    generate
        if (LOG2_D == 0) begin : g_round_bypass
            assign result = N'(sum);
        end else begin : g_round
            logic [ACCW:0] rnd_sum;
            logic [ACCW:0] rnd_shift;
            assign rnd_sum   = {1'b0, sum} + (ACCW+1)'(1 << (LOG2_D - 1));
            assign rnd_shift = rnd_sum >> LOG2_D;
            // Saturation guards the general case; a sum of D N-bit samples
            // cannot actually exceed full scale after the shift.
            assign result = (|rnd_shift[ACCW:N]) ? {N{1'b1}} : rnd_shift[N-1:0];
        end
    endgenerate
`else
    assign result = N'(sum >> LOG2_D);
`endif

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign o_valid = (count_q != '0);
    assign pop     = o_valid & i_ready;
    assign push    = i_en & phase_last;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push & (~full | pop);

    // Next-state for accumulator, phase, FIFO pointers, occupancy and overflow.
    always_comb begin
        acc_d    = acc_q;
        phase_d  = phase_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (i_en) begin
            if (phase_last) begin
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + 1'b1;
            end
        end
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push & ~do_push) ovf_d = 1'b1;
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            acc_q    <= '0;
            phase_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            phase_q  <= phase_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (i_rst && do_push) mem_q[wr_ptr_q] <= result;
    end

    assign o_data     = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_level    = count_q;
    assign o_overflow = ovf_q;

endmodule
